// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned PC_STEP    = 4;

  // Bits needed to hold values 0 .. value-1 (minimum 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/mips_ifetch_fifo.sv
// In-order prefetch queue with a registered head entry so the consumer side
// sees only flops; flush drops every entry in one cycle.
module mips_ifetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned  DEPTH    = 4,
  parameter int unsigned  W        = 64,
  parameter logic [W-1:0] RST_HEAD = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [W-1:0]                i_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output logic [W-1:0]                o_head,
  output logic [clog2(DEPTH+1)-1:0]   o_count,
  output logic                        o_empty
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic [W-1:0]     r_head;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_left;
  logic [CNT_W-1:0] w_count_nxt;
  logic [W-1:0]     w_head_nxt;

  // Next head: bypass the incoming word when nothing older remains.
  always_comb begin
    w_do_pop     = i_pop & r_valid;
    w_do_push    = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);
    w_left       = r_count - CNT_W'(w_do_pop);
    w_count_nxt  = w_left + CNT_W'(w_do_push);
    w_head_nxt   = (w_left == '0) ? i_data : r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= RST_HEAD;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_empty = ~r_valid;

endmodule

// File: rtl/mips_ifetch.sv
// Instruction-fetch front end: credit-limited request issue to a variable
// latency memory, in-order prefetch queue, and redirect with stale-response drop.
module mips_ifetch
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;

  logic [ADDR_W-1:0] w_redir_pc;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_out_nxt;
  logic              w_credit;
  logic              w_grant;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;

  // Queue space is reserved at issue, so in-flight plus queued never exceeds DEPTH.
  always_comb begin
    w_credit   = (({1'b0, r_outstanding} + {1'b0, w_count}) < SUM_W'(DEPTH));
    w_grant    = imem_req & imem_gnt;
    w_resp     = imem_rvalid & (r_outstanding != '0);
    w_out_nxt  = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
    w_push     = w_resp & ~redirect & (r_discard == '0);
    w_pop      = inst_ready & ~redirect;
    w_redir_pc = redirect_pc & ~ADDR_W'(3);
  end

  assign imem_req  = rst_n & ~redirect & w_credit;
  assign imem_addr = r_fetch_pc;

  // Redirect reloads both PCs and marks every still-in-flight word as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (redirect) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_discard  <= w_out_nxt;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        if (w_resp) begin
          if (r_discard != '0) r_discard <= r_discard - CNT_W'(1);
          else                 r_resp_pc <= r_resp_pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  mips_ifetch_fifo #(
    .DEPTH    (DEPTH),
    .W        (ENT_W),
    .RST_HEAD ({RESET_PC, {INST_W{1'b0}}})
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign inst_valid = ~w_empty;
  assign inst       = w_head[INST_W-1:0];
  assign inst_pc    = w_head[ENT_W-1:INST_W];

endmodule

// File: tb/tb_mips_ifetch.sv
// Directed bench for mips_ifetch with a latency-configurable in-order memory model.
module tb_mips_ifetch;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          gnt_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned lat = 1;
  int unsigned cyc = 0;
  int unsigned n_grants = 0;
  logic [31:0] addr_q[$];
  int unsigned due_q[$];

  assign imem_gnt = gnt_en;

  always #5 clk = ~clk;

  mips_ifetch #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: records grants, answers in order 'lat' cycles after the grant.
  always @(posedge clk) begin
    if (!rst_n) begin
      addr_q.delete();
      due_q.delete();
    end else begin
      cyc++;
      if (imem_rvalid && addr_q.size() > 0) begin
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end
      if (imem_req && imem_gnt) begin
        addr_q.push_back(imem_addr);
        due_q.push_back(cyc + lat - 1);
        n_grants++;
      end
    end
    #1;
    if (rst_n && addr_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(addr_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic do_reset(input int unsigned l, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    inst_ready = rdy; gnt_en = 1'b1; lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gnt_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got=%h want=0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h want=0", inst_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset(1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      exp = 32'(4 * k);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp) begin
        n_bad++; $display("FAIL stream_req k=%0d got=%b/%h want=1/%h", k, imem_req, imem_addr, exp);
      end
      n_cmp++;
      if (k >= 2) begin
        exp = 32'(4 * (k - 2));
        if (inst_valid !== 1'b1 || inst_pc !== exp || inst !== mem_word(exp)) begin
          n_bad++; $display("FAIL stream_out k=%0d got=%b/%h/%h want=1/%h/%h", k, inst_valid, inst_pc, inst, exp, mem_word(exp));
        end
      end else if (inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL stream_early k=%0d valid=%b want=0", k, inst_valid);
      end
    end
  endtask

  task automatic test_stall();
    int unsigned g0;
    logic [31:0] exp;
    do_reset(1, 1'b0);
    g0 = n_grants;
    repeat (10) @(negedge clk);
    n_cmp++; if (n_grants - g0 != 4) begin n_bad++; $display("FAIL stall_grants got=%0d want=4", n_grants - g0); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req got=%b want=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL stall_addr got=%h want=10", imem_addr); end
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL stall_head got=%b/%h want=1/0", inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      exp = 32'(4 * k);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== exp || inst !== mem_word(exp)) begin
        n_bad++; $display("FAIL stall_drain k=%0d got=%b/%h/%h want=1/%h/%h", k, inst_valid, inst_pc, inst, exp, mem_word(exp));
      end
      if (k == 1) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          n_bad++; $display("FAIL stall_resume got=%b/%h want=1/10", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    int wait_c;
    do_reset(3, 1'b1);
    repeat (4) @(negedge clk);
    gnt_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      n_bad++; $display("FAIL redir_pre got=%b/%h want=1/4", inst_valid, inst_pc);
    end
    redirect = 1'b1; redirect_pc = 32'h100; gnt_en = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req got=%b want=0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL redir_post got=%b/%b/%h want=0/1/100", inst_valid, imem_req, imem_addr);
    end
    wait_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (inst_valid) begin wait_c = c; break; end
    end
    n_cmp++;
    if (wait_c != 4 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
      n_bad++; $display("FAIL redir_first got=c%0d/%h/%h want=c4/100/%h", wait_c, inst_pc, inst, mem_word(32'h100));
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin
      n_bad++; $display("FAIL redir_second got=%b/%h want=1/104", inst_valid, inst_pc);
    end
  endtask

  task automatic test_align_wrap();
    do_reset(1, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL align_addr got=%b/%h want=1/100", imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_top got=%b/%h want=1/fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL wrap_out0 got=%b/%h/%h want=1/fffffffc/%h", inst_valid, inst_pc, inst, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
      n_bad++; $display("FAIL wrap_out1 got=%b/%h/%h want=1/0/%h", inst_valid, inst_pc, inst, mem_word(32'h0));
    end
  endtask

  task automatic test_reset_midburst();
    do_reset(1, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst !== mem_word(32'h0)) begin
      n_bad++; $display("FAIL mid_pre got=%b/%h want=1/%h", inst_valid, inst, mem_word(32'h0));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset got=%b/%b/%h/%h/%h want=0/0/0/0/0", inst_valid, imem_req, imem_addr, inst, inst_pc);
    end
    repeat (2) @(negedge clk);
    inst_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL mid_restart got=%b/%h want=1/0", imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
      n_bad++; $display("FAIL mid_first got=%b/%h/%h want=1/0/%h", inst_valid, inst_pc, inst, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_align_wrap();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
